// File: rtl/pixel_writer_if.sv
// Pixel command and byte-wide memory bus seen by pixel_writer.
// master = the writer itself; slave = the pixel source / memory side.
interface pixel_writer_if;
    logic        pixel_data_rdy;
    logic [11:0] X_coord;
    logic [11:0] Y_coord;
    logic [7:0]  color;
    logic [1:0]  bpp_mode;
    logic [19:0] base_addr;
    logic [11:0] row_bytes;
    logic [11:0] max_x;
    logic [11:0] max_y;
    logic        draw_busy;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] pixels_written;

    modport master (
        input  pixel_data_rdy, X_coord, Y_coord, color, bpp_mode,
               base_addr, row_bytes, max_x, max_y, mem_ack, mem_rdata,
        output draw_busy, mem_req, mem_we, mem_addr, mem_wdata, pixels_written
    );

    modport slave (
        output pixel_data_rdy, X_coord, Y_coord, color, bpp_mode,
               base_addr, row_bytes, max_x, max_y, mem_ack, mem_rdata,
        input  draw_busy, mem_req, mem_we, mem_addr, mem_wdata, pixels_written
    );
endinterface

// File: rtl/pixel_writer.sv
// Writes one clipped pixel into a packed 1/2/4/8 bpp framebuffer,
// using read-modify-write for sub-byte modes (pixels packed MSB-first).
module pixel_writer (
    input  logic               clk,
    input  logic               reset,
    pixel_writer_if.master     bus
);
    typedef enum logic [1:0] {IDLE, CALC, RD, WR} state_t;

    state_t      r_state;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [7:0]  r_color;
    logic [1:0]  r_bpp_mode;
    logic [19:0] r_base;
    logic [11:0] r_row_bytes;
    logic [2:0]  r_shift;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [19:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic [15:0] r_pixels_written;

    logic        w_clip;
    logic [3:0]  w_bpp;
    logic [7:0]  w_mask;
    logic [13:0] w_bitpos;
    logic [19:0] w_addr;
    logic [2:0]  w_shift;
    logic [7:0]  w_merged;

    // Coordinates that pass this test are non-negative, so an unsigned
    // compare against the limits is exact.
    assign w_clip = bus.X_coord[11] | bus.Y_coord[11] |
                    (bus.X_coord > bus.max_x) | (bus.Y_coord > bus.max_y);

    assign w_bpp    = 4'd1 << r_bpp_mode;
    assign w_bitpos = {3'b000, r_x} << r_bpp_mode;
    assign w_addr   = r_base + (20'(r_y) * 20'(r_row_bytes)) + 20'(w_bitpos[13:3]);
    assign w_shift  = 3'(4'd8 - w_bpp - {1'b0, w_bitpos[2:0]});

    always_comb begin
        w_mask = 8'h01;
        case (r_bpp_mode)
            2'b00:   w_mask = 8'h01;
            2'b01:   w_mask = 8'h03;
            2'b10:   w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
    end

    assign w_merged = (bus.mem_rdata & ~(w_mask << r_shift)) |
                      ((r_color & w_mask) << r_shift);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_x              <= '0;
            r_y              <= '0;
            r_color          <= '0;
            r_bpp_mode       <= '0;
            r_base           <= '0;
            r_row_bytes      <= '0;
            r_shift          <= '0;
            r_mem_req        <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_pixels_written <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.pixel_data_rdy && !w_clip) begin
                        r_x         <= bus.X_coord[10:0];
                        r_y         <= bus.Y_coord[10:0];
                        r_color     <= bus.color;
                        r_bpp_mode  <= bus.bpp_mode;
                        r_base      <= bus.base_addr;
                        r_row_bytes <= bus.row_bytes;
                        r_state     <= CALC;
                    end
                end
                CALC: begin
                    r_mem_addr <= w_addr;
                    r_shift    <= w_shift;
                    r_mem_req  <= 1'b1;
                    if (r_bpp_mode == 2'b11) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= r_color;
                        r_state     <= WR;
                    end else begin
                        r_mem_we <= 1'b0;
                        r_state  <= RD;
                    end
                end
                RD: begin
                    // Request stays up across the read->write turnaround;
                    // only direction and data change on the read ack.
                    if (bus.mem_ack) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_merged;
                        r_state     <= WR;
                    end
                end
                WR: begin
                    if (bus.mem_ack) begin
                        r_mem_req        <= 1'b0;
                        r_mem_we         <= 1'b0;
                        r_pixels_written <= r_pixels_written + 16'd1;
                        r_state          <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.draw_busy      = (r_state != IDLE);
    assign bus.mem_req        = r_mem_req;
    assign bus.mem_we         = r_mem_we;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_mem_wdata;
    assign bus.pixels_written = r_pixels_written;
endmodule

// File: tb/tb_pixel_writer.sv
// Directed and randomized checks of pixel_writer against a pixel-field
// framebuffer model; the bench acts as pixel source and memory.
module tb_pixel_writer;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_count = 0;

    pixel_writer_if bus ();

    pixel_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte viewed as 8/b pixel fields, field 0 in the most significant bits.
    function automatic logic [7:0] ref_byte(input logic [7:0] old, input int b,
                                            input int x, input logic [7:0] col);
        int ppb  = 8 / b;
        int slot = x % ppb;
        int fmax = 1 << b;
        int val  = 0;
        for (int k = 0; k < ppb; k++) begin
            int f;
            f = (int'(old) >> (8 - b * (k + 1))) % fmax;
            if (k == slot) f = int'(col) % fmax;
            val = val * fmax + f;
        end
        return 8'(val);
    endfunction

    function automatic logic [19:0] ref_addr(input logic [19:0] base, input int y,
                                             input logic [11:0] rowb, input int x, input int b);
        int unsigned a;
        a = int'(base) + y * int'(rowb) + (x * b) / 8;
        return 20'(a);
    endfunction

    task automatic pixel(input int x, input int y, input logic [7:0] col,
                         input logic [1:0] mode, input logic [19:0] base,
                         input logic [11:0] rowb, input logic [11:0] mx,
                         input logic [11:0] my, input int hold_rd, input int hold_wr,
                         input logic [7:0] rdata, input bit hold_rdy);
        int          b;
        bit          clipped;
        logic [19:0] ea;
        logic [7:0]  ew;
        b = 1 << mode;
        clipped = (x < 0) || (y < 0) || (x > int'(mx)) || (y > int'(my));
        @(negedge clk);
        check("idle_busy", bus.draw_busy, 0);
        bus.X_coord = 12'(x);     bus.Y_coord = 12'(y);
        bus.color = col;          bus.bpp_mode = mode;
        bus.base_addr = base;     bus.row_bytes = rowb;
        bus.max_x = mx;           bus.max_y = my;
        bus.pixel_data_rdy = 1'b1;
        @(negedge clk);
        if (!hold_rdy) bus.pixel_data_rdy = 1'b0;
        if (clipped) begin
            bus.pixel_data_rdy = 1'b0;
            check("clip_busy", bus.draw_busy, 0);
            check("clip_req", bus.mem_req, 0);
            bus.mem_ack = 1'b1;            // stray ack with no request
            @(negedge clk);
            bus.mem_ack = 1'b0;
            @(negedge clk);
            check("clip_req2", bus.mem_req, 0);
            check("clip_count", bus.pixels_written, 16'(exp_count));
            return;
        end
        check("calc_busy", bus.draw_busy, 1);
        check("calc_req", bus.mem_req, 0);
        @(negedge clk);
        check("req_up", bus.mem_req, 1);
        ea = ref_addr(base, y, rowb, x, b);
        if (mode != 2'b11) begin
            check("rd_we", bus.mem_we, 0);
            check("rd_addr", bus.mem_addr, ea);
            for (int i = 0; i < hold_rd; i++) begin
                @(negedge clk);
                check("rd_hold_req", bus.mem_req, 1);
                check("rd_hold_addr", bus.mem_addr, ea);
            end
            bus.mem_ack = 1'b1;
            bus.mem_rdata = rdata;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 8'($urandom);
            ew = ref_byte(rdata, b, x, col);
        end else begin
            ew = col;
        end
        check("wr_req", bus.mem_req, 1);
        check("wr_we", bus.mem_we, 1);
        check("wr_addr", bus.mem_addr, ea);
        check("wr_data", bus.mem_wdata, ew);
        for (int i = 0; i < hold_wr; i++) begin
            @(negedge clk);
            check("wr_hold_req", bus.mem_req, 1);
            check("wr_hold_busy", bus.draw_busy, 1);
            check("wr_hold_addr", bus.mem_addr, ea);
            check("wr_hold_data", bus.mem_wdata, ew);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.pixel_data_rdy = 1'b0;
        exp_count = (exp_count + 1) % 65536;
        check("done_req", bus.mem_req, 0);
        check("done_busy", bus.draw_busy, 0);
        check("done_count", bus.pixels_written, 16'(exp_count));
    endtask

    initial begin
        bus.pixel_data_rdy = 1'b0;
        bus.X_coord = '0;  bus.Y_coord = '0;  bus.color = '0;  bus.bpp_mode = '0;
        bus.base_addr = '0; bus.row_bytes = '0; bus.max_x = '0; bus.max_y = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.draw_busy, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_count", bus.pixels_written, 0);
        reset = 1'b0;

        // Worked examples
        pixel(3, 2, 8'h5A, 2'b11, 20'h01000, 12'd640, 12'd639, 12'd479, 0, 0, 8'h00, 0);
        pixel(9, 0, 8'h01, 2'b00, 20'h02000, 12'd80, 12'd639, 12'd479, 0, 0, 8'h00, 0);
        pixel(1, 0, 8'hF3, 2'b10, 20'h03000, 12'd160, 12'd319, 12'd239, 0, 0, 8'hAB, 0);
        pixel(2, 0, 8'h02, 2'b01, 20'h04000, 12'd80, 12'd319, 12'd239, 0, 0, 8'hFF, 0);
        // Clip edges
        pixel(320, 5, 8'h11, 2'b11, 20'h0, 12'd320, 12'd319, 12'd239, 0, 0, 8'h0, 0);
        pixel(-1, 5, 8'h11, 2'b11, 20'h0, 12'd320, 12'd319, 12'd239, 0, 0, 8'h0, 0);
        pixel(319, 239, 8'h22, 2'b11, 20'h0, 12'd320, 12'd319, 12'd239, 0, 0, 8'h0, 0);
        pixel(5, 240, 8'h22, 2'b11, 20'h0, 12'd320, 12'd319, 12'd239, 0, 0, 8'h0, 0);
        // Stalled write, held ready, address wrap
        pixel(7, 3, 8'hC4, 2'b11, 20'h00100, 12'd64, 12'd100, 12'd100, 0, 5, 8'h0, 1);
        pixel(13, 1, 8'h03, 2'b01, 20'hFFFF0, 12'd40, 12'd100, 12'd100, 3, 2, 8'h5C, 1);

        // Reset while a read is outstanding
        @(negedge clk);
        bus.X_coord = 12'd4; bus.Y_coord = 12'd1; bus.color = 8'h01; bus.bpp_mode = 2'b00;
        bus.base_addr = 20'h00500; bus.row_bytes = 12'd10;
        bus.max_x = 12'd100; bus.max_y = 12'd100;
        bus.pixel_data_rdy = 1'b1;
        @(negedge clk);
        bus.pixel_data_rdy = 1'b0;
        @(negedge clk);
        check("rdrst_pre_req", bus.mem_req, 1);
        check("rdrst_pre_we", bus.mem_we, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0;
        check("rdrst_req", bus.mem_req, 0);
        check("rdrst_busy", bus.draw_busy, 0);
        check("rdrst_count", bus.pixels_written, 0);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("rdrst_late_req", bus.mem_req, 0);
        check("rdrst_late_busy", bus.draw_busy, 0);
        check("rdrst_late_count", bus.pixels_written, 0);

        // Randomized pixels
        for (int n = 0; n < 60; n++) begin
            int          mx, my, x, y;
            logic [1:0]  md;
            mx = int'($urandom_range(0, 500));
            my = int'($urandom_range(0, 300));
            x  = int'($urandom_range(0, mx + 6)) - 3;
            y  = int'($urandom_range(0, my + 6)) - 3;
            md = 2'($urandom);
            pixel(x, y, 8'($urandom), md, 20'($urandom), 12'($urandom),
                  12'(mx), 12'(my), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 8'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
